// File: rtl/timer_seq_pkg.sv
// Shared types for the timer sequencer.
// Holds the FSM state encoding and a helper that sizes the prescaler divider.
package timer_seq_pkg;

    // Sequencer states; the encoding is visible in waveforms, so keep it fixed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Divider register width; a ratio of 1 still needs one bit.
    function automatic int unsigned presc_w(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/timer_seq_if.sv
// Control/status bundle between a timer client (master) and timer_sequencer (slave).
//   start, stop     : pulses, begin/restart and abort
//   hold            : level, freeze counting
//   mode_periodic   : 1 periodic, 0 one-shot (latched on accepted start)
//   cmp_val         : terminal value (latched on accepted start)
//   count           : current counter value
//   running, done   : state RUN/HOLD, state DONE
//   tc_pulse        : one-cycle terminal-count pulse
//   evt_cnt         : saturating tally of terminal counts since last start
interface timer_seq_if #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned EVT_W = 8
);
    logic              start;
    logic              stop;
    logic              hold;
    logic              mode_periodic;
    logic [SIZE-1:0]   cmp_val;
    logic [SIZE-1:0]   count;
    logic              running;
    logic              done;
    logic              tc_pulse;
    logic [EVT_W-1:0]  evt_cnt;

    modport master (
        output start, stop, hold, mode_periodic, cmp_val,
        input  count, running, done, tc_pulse, evt_cnt
    );

    modport slave (
        input  start, stop, hold, mode_periodic, cmp_val,
        output count, running, done, tc_pulse, evt_cnt
    );
endinterface

// File: rtl/timer_seq_core.sv
// SIZE-bit up-counter datapath with synchronous clear, enable and compare-equal.
//   clk, rst  : clock, synchronous active-high reset
//   i_clr     : clear to zero (wins over i_en)
//   i_en      : increment by one
//   i_cmp     : compare value
//   o_count   : registered counter value
//   o_eq      : o_count == i_cmp
module timer_seq_core #(
    parameter int unsigned SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic            i_en,
    input  logic [SIZE-1:0] i_cmp,
    output logic [SIZE-1:0] o_count,
    output logic            o_eq
);

    logic [SIZE-1:0] r_count;

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + SIZE'(1);
        end
    end

    assign o_count = r_count;
    assign o_eq    = (r_count == i_cmp);

endmodule

// File: rtl/timer_sequencer.sv
// Run/stop controller for an up-counter timer tile: start/stop/hold sequencing,
// one-shot or periodic operation against a latched compare value, a one-cycle
// terminal-count pulse and a saturating event tally.
//   clk, rst : clock, synchronous active-high reset
//   bus      : timer_seq_if.slave (controls in, count/status out)
// Optional build macro TIMER_SEQ_PRESCALE_EN: counting advances once every
// PRESC_DIV active cycles instead of every active cycle.
module timer_sequencer
    import timer_seq_pkg::*;
#(
    parameter int unsigned SIZE      = 4,
    parameter int unsigned EVT_W     = 8,
    parameter int unsigned PRESC_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    timer_seq_if.slave  bus
);

    // Elaboration-time parameter sanity checks.
    if (SIZE < 2) begin : g_size_chk
        $error("timer_sequencer: SIZE must be >= 2");
    end
    if (PRESC_DIV < 1) begin : g_presc_chk
        $error("timer_sequencer: PRESC_DIV must be >= 1");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [SIZE-1:0]  r_cmp_q;
    logic             r_mode_q;
    logic             r_tc_pulse;
    logic [EVT_W-1:0] r_evt_cnt;

    logic             w_start_ok;
    logic             w_active;
    logic             w_tick;
    logic             w_tc;
    logic             w_clr;
    logic             w_en;
    logic             w_presc_ok;
    logic [SIZE-1:0]  w_count;
    logic             w_eq;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath control. HOLD with hold released counts in the
    // same cycle it returns to RUN, so a hold of N cycles delays exactly N.
    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_active     = 1'b0;
        w_tick       = 1'b0;
        w_tc         = 1'b0;
        w_clr        = 1'b0;
        w_en         = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: w_start_ok = bus.start & ~bus.stop;
            ST_RUN,  ST_HOLD: w_active   = ~bus.hold & ~bus.stop;
            default:          ;
        endcase

        w_tick = w_active & w_presc_ok;
        w_tc   = w_tick & w_eq;

        if (bus.stop) begin
            w_state_next = ST_IDLE;
        end else if (w_start_ok) begin
            w_state_next = ST_RUN;
        end else if (r_state == ST_RUN || r_state == ST_HOLD) begin
            if (bus.hold) begin
                w_state_next = ST_HOLD;
            end else if (w_tc && !r_mode_q) begin
                w_state_next = ST_DONE;
            end else begin
                w_state_next = ST_RUN;
            end
        end

        w_clr = bus.stop | w_start_ok | w_tc;
        w_en  = w_tick & ~w_eq;
    end

`ifdef TIMER_SEQ_PRESCALE_EN
    localparam int unsigned PW = presc_w(PRESC_DIV);
    logic [PW-1:0] r_presc;

    assign w_presc_ok = (r_presc == PW'(PRESC_DIV - 1));

    // Prescale divider: advances only on active cycles, so HOLD freezes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (bus.stop || w_start_ok) begin
            r_presc <= '0;
        end else if (w_active) begin
            r_presc <= w_presc_ok ? '0 : r_presc + PW'(1);
        end
    end
`else
    assign w_presc_ok = 1'b1;
`endif

    // Run configuration captured on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_q  <= '0;
            r_mode_q <= 1'b0;
        end else if (w_start_ok) begin
            r_cmp_q  <= bus.cmp_val;
            r_mode_q <= bus.mode_periodic;
        end
    end

    // Terminal-count pulse and saturating event tally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tc_pulse <= 1'b0;
            r_evt_cnt  <= '0;
        end else begin
            r_tc_pulse <= w_tc;
            if (bus.stop || w_start_ok) begin
                r_evt_cnt <= '0;
            end else if (w_tc && (r_evt_cnt != '1)) begin
                r_evt_cnt <= r_evt_cnt + EVT_W'(1);
            end
        end
    end

    timer_seq_core #(.SIZE(SIZE)) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_cmp   (r_cmp_q),
        .o_count (w_count),
        .o_eq    (w_eq)
    );

    assign bus.count    = w_count;
    assign bus.running  = (r_state == ST_RUN) || (r_state == ST_HOLD);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.tc_pulse = r_tc_pulse;
    assign bus.evt_cnt  = r_evt_cnt;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: two instances (8-bit and 2-bit event tally) share
// the same stimulus; a behavioural model predicts every post-edge output set,
// pushes it into a queue, and a monitor pops and compares after each edge.
module tb_timer_sequencer;

    localparam int unsigned SIZE   = 4;
    localparam int unsigned EVT_W  = 8;
    localparam int unsigned EVT_W2 = 2;
`ifdef TIMER_SEQ_PRESCALE_EN
    localparam int DIV = 4;
`else
    localparam int DIV = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    timer_seq_if #(.SIZE(SIZE), .EVT_W(EVT_W))  bus();
    timer_seq_if #(.SIZE(SIZE), .EVT_W(EVT_W2)) bus2();

    assign bus2.start         = bus.start;
    assign bus2.stop          = bus.stop;
    assign bus2.hold          = bus.hold;
    assign bus2.mode_periodic = bus.mode_periodic;
    assign bus2.cmp_val       = bus.cmp_val;

    timer_sequencer #(.SIZE(SIZE), .EVT_W(EVT_W), .PRESC_DIV(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    timer_sequencer #(.SIZE(SIZE), .EVT_W(EVT_W2), .PRESC_DIV(4)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        int count;
        bit running;
        bit done;
        bit tc;
        int evt;
        int evt2;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: a timer is either active (running/holding), done, or idle.
    bit m_active, m_done, m_mode, m_tc;
    int m_count, m_cmp, m_evt, m_presc;

    task automatic step(input bit r, input bit st, input bit sp, input bit h,
                        input bit m, input int c);
        exp_t e;
        @(negedge clk);
        rst               = r;
        bus.start         = st;
        bus.stop          = sp;
        bus.hold          = h;
        bus.mode_periodic = m;
        bus.cmp_val       = 4'(c);

        m_tc = 1'b0;
        if (r) begin
            m_active = 0; m_done = 0; m_mode = 0;
            m_count = 0; m_evt = 0; m_cmp = 0; m_presc = 0;
        end else if (sp) begin
            m_active = 0; m_done = 0;
            m_count = 0; m_evt = 0; m_presc = 0;
        end else if (st && !m_active) begin
            m_active = 1; m_done = 0;
            m_count = 0; m_evt = 0; m_presc = 0;
            m_cmp = c; m_mode = m;
        end else if (m_active && !h) begin
            m_presc = (m_presc + 1) % DIV;
            if (m_presc == 0) begin
                if (m_count == m_cmp) begin
                    m_tc = 1'b1;
                    m_evt++;
                    m_count = 0;
                    if (!m_mode) begin
                        m_active = 0;
                        m_done   = 1;
                    end
                end else begin
                    m_count++;
                end
            end
        end

        e.count   = m_count;
        e.running = m_active;
        e.done    = m_done;
        e.tc      = m_tc;
        e.evt     = (m_evt > 255) ? 255 : m_evt;
        e.evt2    = (m_evt > 3) ? 3 : m_evt;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input bit m, input int c);
        repeat (n) step(0, 0, 0, 0, m, c);
    endtask

    // Monitor: compare the DUT outputs just after each edge with the oldest prediction.
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            n_checks++;
            if (bus.count    !== 4'(mon_e.count) ||
                bus.running  !== mon_e.running   ||
                bus.done     !== mon_e.done      ||
                bus.tc_pulse !== mon_e.tc        ||
                bus.evt_cnt  !== 8'(mon_e.evt)   ||
                bus2.evt_cnt !== 2'(mon_e.evt2)  ||
                bus2.tc_pulse !== mon_e.tc) begin
                n_fail++;
                $display("FAIL outputs t=%0t got cnt=%0d run=%b done=%b tc=%b evt=%0d evt2=%0d want cnt=%0d run=%b done=%b tc=%b evt=%0d evt2=%0d",
                         $time, bus.count, bus.running, bus.done, bus.tc_pulse,
                         bus.evt_cnt, bus2.evt_cnt, mon_e.count, mon_e.running,
                         mon_e.done, mon_e.tc, mon_e.evt, mon_e.evt2);
            end
        end
    end

    initial begin
        bus.start = 0; bus.stop = 0; bus.hold = 0;
        bus.mode_periodic = 0; bus.cmp_val = '0;

        // Reset, then one-shot to 5.
        repeat (2) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 5);
        idle(9, 0, 5);

        // Periodic cmp 3, compare value changed mid-run.
        step(0, 1, 0, 0, 1, 3);
        idle(10, 1, 3);
        idle(10, 1, 9);

        // Periodic cmp 7, hold for 3 cycles at count 4.
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1, 7);
        idle(4, 1, 7);
        repeat (3) step(0, 0, 0, 1, 1, 7);
        idle(12, 1, 7);

        // start alone in RUN ignored; stop+start together aborts.
        step(0, 1, 0, 0, 0, 2);
        idle(3, 0, 2);
        step(0, 1, 1, 0, 1, 3);
        idle(3, 1, 3);

        // start with hold asserted.
        step(0, 1, 0, 1, 1, 2);
        repeat (2) step(0, 0, 0, 1, 1, 2);
        idle(4, 1, 2);

        // Reset held two cycles mid-run.
        repeat (2) step(1, 0, 0, 0, 0, 0);
        idle(2, 0, 0);

        // cmp 0: terminal count every tick; tally saturates on the 2-bit instance.
        step(0, 1, 0, 0, 1, 0);
        idle(8, 1, 0);

        // cmp 15: full wrap.
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1, 15);
        idle(34, 1, 15);

        // One-shot to DONE, then restart from DONE, then stop from DONE.
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1);
        idle(4, 0, 1);
        step(0, 1, 0, 0, 0, 2);
        idle(5, 0, 2);
        step(0, 0, 1, 0, 0, 2);
        idle(2, 0, 2);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)));
        end
        idle(3, 0, 0);

        @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
